// File: rtl/pipe_stage_reg_v2.sv
// Elastic pipeline-stage register: main entry plus one skid entry, valid/ready on both sides.
// Optional build macro PIPE_HOLD_TNEW_DEC_EN: Tnew of held entries counts down while stalled.
module pipe_stage_reg_v2 #(
  parameter int                DATA_W   = 32,
  parameter int                LANES    = 6,
  parameter int                PC_LANE  = 3,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_3000,
  parameter int                TNEW_W   = 2,
  parameter bit                TNEW_DEC = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [4:0]              in_a3,
  input  logic [TNEW_W-1:0]       in_tnew,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [4:0]              out_a3,
  output logic [TNEW_W-1:0]       out_tnew,
  output logic [1:0]              occ
);

  localparam int PW = LANES * DATA_W;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  logic              main_v;
  logic [PW-1:0]     main_data;
  logic [4:0]        main_a3;
  logic [TNEW_W-1:0] main_tnew;
  logic              skid_v;
  logic [PW-1:0]     skid_data;
  logic [4:0]        skid_a3;
  logic [TNEW_W-1:0] skid_tnew;

  logic [PW-1:0]     bubble_data;
  logic [TNEW_W-1:0] load_tnew;
  logic [TNEW_W-1:0] main_tnew_held;
  logic [TNEW_W-1:0] skid_tnew_held;
  logic              in_fire;
  logic              main_adv;

  always_comb begin
    bubble_data = '0;
    bubble_data[PC_LANE*DATA_W +: DATA_W] = RESET_PC;
  end

  assign load_tnew = TNEW_DEC ? sat_dec(in_tnew) : in_tnew;

`ifdef PIPE_HOLD_TNEW_DEC_EN
  assign main_tnew_held = sat_dec(main_tnew);
  assign skid_tnew_held = sat_dec(skid_tnew);
`else
  assign main_tnew_held = main_tnew;
  assign skid_tnew_held = skid_tnew;
`endif

  assign in_ready = ~skid_v;
  assign in_fire  = in_valid & in_ready;
  // main may take a new value whenever it is empty or its entry leaves this cycle
  assign main_adv = ~main_v | out_ready;

  // ---- storage stage: main + skid entries ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_v    <= 1'b0;
      main_data <= bubble_data;
      main_a3   <= '0;
      main_tnew <= '0;
      skid_v    <= 1'b0;
      skid_data <= bubble_data;
      skid_a3   <= '0;
      skid_tnew <= '0;
    end else if (main_adv) begin
      if (skid_v) begin
        main_v    <= 1'b1;
        main_data <= skid_data;
        main_a3   <= skid_a3;
        main_tnew <= skid_tnew;
        skid_v    <= 1'b0;
        skid_data <= bubble_data;
        skid_a3   <= '0;
        skid_tnew <= '0;
      end else if (in_fire) begin
        main_v    <= 1'b1;
        main_data <= in_data;
        main_a3   <= in_a3;
        main_tnew <= load_tnew;
      end else begin
        main_v    <= 1'b0;
        main_data <= bubble_data;
        main_a3   <= '0;
        main_tnew <= '0;
      end
    end else begin
      main_tnew <= main_tnew_held;
      if (in_fire) begin
        skid_v    <= 1'b1;
        skid_data <= in_data;
        skid_a3   <= in_a3;
        skid_tnew <= load_tnew;
      end else if (skid_v) begin
        skid_tnew <= skid_tnew_held;
      end
    end
  end

  // ---- output stage: driven only from the main entry ----
  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_a3    = main_v ? main_a3 : 5'd0;
  assign out_tnew  = main_v ? main_tnew : '0;
  assign occ       = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: doc/pipe_stage_reg_v2.md
Name: pipe_stage_reg_v2

Overview:
Parametrised elastic pipeline-stage register, the successor to the fixed D/E register in the MIPS core. It carries LANES payload words plus the destination register (A3) and the hazard Tnew count. It uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops an instruction. Flush inserts a bubble, and Tnew is adjusted per stage for the hazard unit.

Parameters:
DATA_W, 32, width of each payload lane
LANES, 6, number of payload lanes (V1, V2, E32, PC, Instr, spare)
PC_LANE, 3, index of the lane holding the PC; a bubble writes RESET_PC into this lane
RESET_PC, 32'h0000_3000, PC value for bubble/reset entries
TNEW_W, 2, Tnew width
TNEW_DEC, 0, when 1, stored Tnew = in_tnew-1 saturating at 0; when 0, stored unchanged

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
flush  in  1  synchronous clear of both entries (bubble insert)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered, equals !skid_v
in_data  in  LANES*DATA_W  payload, lane i at [i*DATA_W +: DATA_W]
in_a3  in  5  destination register
in_tnew  in  TNEW_W  Tnew of incoming instruction
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_data  out  LANES*DATA_W  main entry payload
out_a3  out  5  main entry A3; 0 when invalid
out_tnew  out  TNEW_W  main entry Tnew; 0 when invalid
occ  out  2  entries held (0..2)

Behaviour:
- Storage: a main entry (main_v, data, a3, tnew) and a skid entry (skid_v, same fields). Outputs are driven directly from the main entry; there is no combinational path from in_* to out_*.
- Bubble contents: all lanes 0 except PC_LANE = RESET_PC; a3 = 0; tnew = 0.
- Reset or flush (reset has priority; the two are equivalent): main_v = 0, skid_v = 0, both entries take bubble contents. After the edge: in_ready = 1, out_valid = 0, occ = 0. An in_fire in the same cycle is dropped.
- Per-cycle signals: in_fire = in_valid & in_ready; out_fire = main_v & out_ready.
- Load value L: data/a3 taken as supplied; tnew = TNEW_DEC ? sat_dec(in_tnew) : in_tnew.
- When !main_v or out_fire:
  - if skid_v: main <= skid, skid_v <= 0 (in_fire is impossible because in_ready = 0);
  - else if in_fire: main <= L, main_v <= 1;
  - else: main <= bubble, main_v <= 0.
- When main_v & !out_ready:
  - main holds;
  - if in_fire: skid <= L, skid_v <= 1.
- Latency is 1 cycle from in_fire to out_valid when the stage is empty.
- Throughput is 1 entry/cycle while out_ready = 1.
- With a single stall cycle, at most 1 extra entry is absorbed; in_ready drops the cycle after the skid fills.
- Ordering is strict FIFO: the skid entry always moves into main before any new input.
- occ = main_v + skid_v.
- out_a3 and out_tnew read 0 whenever main_v = 0, so the hazard unit sees no false dependency.
- in_valid = 1 with X payload while in_ready = 0 must not corrupt state.

Optional Feature:
- Macro: PIPE_HOLD_TNEW_DEC_EN.
- Defined: while main_v & !out_ready (stalled), the main entry's tnew decrements by 1 each cycle, saturating at 0; the skid entry's tnew also decrements each cycle it is held. This models a result progressing while the downstream stage stalls.
- Undefined: tnew is frozen while held.

Test Plan:
- Reset then idle -> out_valid = 0, occ = 0, in_ready = 1, out_data PC lane = 32'h3000, out_a3 = 0, out_tnew = 0.
- out_ready = 1, feed 4 entries back-to-back (A3 = 1,2,3,4; tnew = 2) -> each appears 1 cycle later in order; TNEW_DEC = 1 gives out_tnew = 1; no bubbles between entries.
- Entry A in main, out_ready = 0, feed B then C -> B goes to skid, occ = 2, in_ready = 0, C held upstream. Release out_ready -> A, B, C emerge in order with no loss or duplication.
- occ = 2 and flush = 1 with in_valid = 1 -> next cycle occ = 0, out_valid = 0, PC lane = RESET_PC, input dropped.
- With PIPE_HOLD_TNEW_DEC_EN defined: main tnew = 2, out_ready = 0 for 3 cycles -> out_tnew reads 2, 1, 0, 0. Without the macro it stays 2.
- reset asserted with occ = 2 and out_ready = 1 -> reset wins, no out_fire is observed after the edge, state is identical to power-up.
